// File: rtl/led_pkg.sv
// Shared types and default timing for the LED pulse stretcher.
// Default cycle counts assume a 100 MHz clock (10 ms on / 10 ms off).
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } led_state_t;

  localparam int unsigned DEF_ON_CYCLES  = 32'd1000000;
  localparam int unsigned DEF_GAP_CYCLES = 32'd1000000;
  localparam int unsigned DEF_CNT_W      = 32'd20;

endpackage

// File: rtl/cycle_timer.sv
// Up-counter from 0 to limit-1 that flags its final cycle and then holds.
// The owner restarts it with clear on every state entry.
module cycle_timer #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count_r;
  logic             at_end_s;

  // final-cycle detect against the current limit
  always_comb begin
    at_end_s = (count_r == (limit - CNT_W'(1)));
  end

  // counter: restart on clear, saturate at limit-1 instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (!at_end_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = at_end_s;

endmodule

// File: rtl/led_stretch.sv
// Stretches single-cycle events into visible LED blinks with a forced off gap.
// Define LED_STRETCH_QUEUE_EN to queue events seen during a blink; otherwise
// events during ON retrigger the pulse and events during GAP are dropped.
module led_stretch
  import led_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evt_i,
  output logic              led_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              ovf_o
);

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES);

  led_state_t       state_r, state_s;
  logic             timer_clr_s, timer_done_s;
  logic [CNT_W-1:0] limit_s;
  logic             led_r, busy_r, ovf_r, ovf_s;

`ifdef LED_STRETCH_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  logic [PEND_W-1:0] pend_r, pend_s;
`endif

  // one timer serves both phases; its limit follows the current state
  always_comb begin
    if (state_r == ST_ON) begin
      limit_s = ON_LIM;
    end else begin
      limit_s = GAP_LIM;
    end
  end

  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clr_s),
    .limit (limit_s),
    .done  (timer_done_s)
  );

  // next-state, timer restart and event bookkeeping
  always_comb begin
    state_s     = state_r;
    timer_clr_s = 1'b0;
    ovf_s       = ovf_r;
`ifdef LED_STRETCH_QUEUE_EN
    pend_s      = pend_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (evt_i) begin
          state_s     = ST_ON;
          timer_clr_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ON: begin
`ifdef LED_STRETCH_QUEUE_EN
        if (evt_i && (pend_r == PEND_MAX)) begin
          ovf_s = 1'b1;
        end else if (evt_i) begin
          pend_s = pend_r + PEND_W'(1);
        end else begin
          pend_s = pend_r;
        end
        if (timer_done_s) begin
          state_s     = ST_GAP;
          timer_clr_s = 1'b1;
        end else begin
          state_s = ST_ON;
        end
`else
        if (evt_i) begin
          timer_clr_s = 1'b1;
        end else if (timer_done_s) begin
          state_s     = ST_GAP;
          timer_clr_s = 1'b1;
        end else begin
          state_s = ST_ON;
        end
`endif
      end
      ST_GAP: begin
`ifdef LED_STRETCH_QUEUE_EN
        // a fresh event on the last gap cycle stands in for a dequeue
        if (timer_done_s && (evt_i || (pend_r != '0))) begin
          state_s     = ST_ON;
          timer_clr_s = 1'b1;
          if (!evt_i) begin
            pend_s = pend_r - PEND_W'(1);
          end else begin
            pend_s = pend_r;
          end
        end else if (timer_done_s) begin
          state_s     = ST_IDLE;
          timer_clr_s = 1'b1;
        end else if (evt_i && (pend_r == PEND_MAX)) begin
          ovf_s = 1'b1;
        end else if (evt_i) begin
          pend_s = pend_r + PEND_W'(1);
        end else begin
          state_s = ST_GAP;
        end
`else
        if (evt_i) begin
          ovf_s = 1'b1;
        end else begin
          ovf_s = ovf_r;
        end
        if (timer_done_s) begin
          state_s     = ST_IDLE;
          timer_clr_s = 1'b1;
        end else begin
          state_s = ST_GAP;
        end
`endif
      end
      default: begin
        state_s     = ST_IDLE;
        timer_clr_s = 1'b1;
      end
    endcase
  end

  // state and outputs registered from the next state for 1-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      led_r   <= 1'b0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
`ifdef LED_STRETCH_QUEUE_EN
      pend_r  <= '0;
`endif
    end else begin
      state_r <= state_s;
      led_r   <= (state_s == ST_ON);
      busy_r  <= (state_s != ST_IDLE);
      ovf_r   <= ovf_s;
`ifdef LED_STRETCH_QUEUE_EN
      pend_r  <= pend_s;
`endif
    end
  end

  assign led_o  = led_r;
  assign busy_o = busy_r;
  assign ovf_o  = ovf_r;
`ifdef LED_STRETCH_QUEUE_EN
  assign pend_o = pend_r;
`else
  assign pend_o = '0;
`endif

endmodule

// File: tb/tb_led_stretch.sv
// Self-checking bench for led_stretch (ON=4, GAP=3, PEND_W=2) against a
// remaining-cycles reference model; covers both LED_STRETCH_QUEUE_EN builds.
module tb_led_stretch;

  localparam int ON   = 4;
  localparam int GAP  = 3;
  localparam int PW   = 2;
  localparam int PMAX = 3;
`ifdef LED_STRETCH_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          evt_i = 1'b0;
  logic          led_o, busy_o, ovf_o;
  logic [PW-1:0] pend_o;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: cycles left in the current ON / GAP phase, queue depth
  int on_rem  = 0;
  int gap_rem = 0;
  int m_pend  = 0;
  bit m_ovf   = 1'b0;

  always #5 clk = ~clk;

  led_stretch #(
    .ON_CYCLES (ON),
    .GAP_CYCLES(GAP),
    .CNT_W     (8),
    .PEND_W    (PW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .evt_i  (evt_i),
    .led_o  (led_o),
    .busy_o (busy_o),
    .pend_o (pend_o),
    .ovf_o  (ovf_o)
  );

  task automatic model_reset();
    on_rem = 0; gap_rem = 0; m_pend = 0; m_ovf = 1'b0;
  endtask

  task automatic model_enqueue();
    if (m_pend == PMAX) m_ovf = 1'b1;
    else m_pend++;
  endtask

  task automatic model_step(input bit e);
    if (on_rem > 0) begin
      if (e && !QUEUE) begin
        on_rem = ON;
      end else begin
        if (e) model_enqueue();
        if (on_rem == 1) begin on_rem = 0; gap_rem = GAP; end
        else on_rem--;
      end
    end else if (gap_rem > 0) begin
      if (!QUEUE) begin
        if (e) m_ovf = 1'b1;
        gap_rem--;
      end else if (gap_rem == 1) begin
        gap_rem = 0;
        if (e) on_rem = ON;
        else if (m_pend > 0) begin m_pend--; on_rem = ON; end
      end else begin
        if (e) model_enqueue();
        gap_rem--;
      end
    end else if (e) begin
      on_rem = ON;
    end
  endtask

  function automatic logic [PW+2:0] model_outs();
    return {on_rem > 0, (on_rem > 0) || (gap_rem > 0), PW'(m_pend), m_ovf};
  endfunction

  task automatic tick(input bit e);
    evt_i = e;
    @(posedge clk);
    model_step(e);
    #1;
  endtask

  task automatic do_reset();
    evt_i = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    evt_i = 1'b0;
    #12;
    n_tests++;
    if ({led_o, busy_o, pend_o, ovf_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want 0", {led_o, busy_o, pend_o, ovf_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      n_tests++;
      if ({led_o, busy_o, pend_o, ovf_o} !== model_outs()) begin
        n_fail++;
        $display("FAIL reset_idle: got %b want %b", {led_o, busy_o, pend_o, ovf_o}, model_outs());
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    tick(1'b1);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({led_o, busy_o} !== {i < ON, i < ON + GAP} ||
          {led_o, busy_o, pend_o, ovf_o} !== model_outs()) begin
        n_fail++;
        $display("FAIL single cyc%0d: got %b want led/busy %b model %b", 11 + i,
                 {led_o, busy_o, pend_o, ovf_o}, {i < ON, i < ON + GAP}, model_outs());
      end
      tick(1'b0);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    tick(1'b1);
    n_tests++;
    if (led_o !== 1'b1) begin
      n_fail++;
      $display("FAIL retrig_c11: got led %b want 1", led_o);
    end
    tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < ON; i++) begin
      n_tests++;
      if (led_o !== 1'b1 || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL retrig_on c%0d: got led %b busy %b want 1 1", 13 + i, led_o, busy_o);
      end
      tick(1'b0);
    end
    n_tests++;
    if ({led_o, busy_o, ovf_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL retrig_gap: got %b want 010", {led_o, busy_o, ovf_o});
    end
    tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (led_o !== 1'b0 || ovf_o !== 1'b1 ||
          {led_o, busy_o, pend_o, ovf_o} !== model_outs()) begin
        n_fail++;
        $display("FAIL gap_drop c%0d: got %b want %b", 18 + i,
                 {led_o, busy_o, pend_o, ovf_o}, model_outs());
      end
      tick(1'b0);
    end
  endtask

  task automatic test_queue();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1);
    for (int c = 14; c <= 40; c++) begin
      logic          e_led, e_busy;
      logic [PW-1:0] e_pend;
      e_led  = (c <= 35) && (((c - 11) % 7) < 4);
      e_busy = (c <= 38);
      e_pend = (c < 18) ? PW'(3) : (c < 25) ? PW'(2) : (c < 32) ? PW'(1) : PW'(0);
      n_tests++;
      if ({led_o, busy_o, pend_o, ovf_o} !== {e_led, e_busy, e_pend, 1'b0}) begin
        n_fail++;
        $display("FAIL queue c%0d: got %b want %b", c,
                 {led_o, busy_o, pend_o, ovf_o}, {e_led, e_busy, e_pend, 1'b0});
      end
      tick(1'b0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1);
    n_tests++;
    if ({pend_o, ovf_o} !== {PW'(3), 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_sat: got pend %0d ovf %b want 3 1", pend_o, ovf_o);
    end
    for (int i = 0; i < 35; i++) tick(1'b0);
    n_tests++;
    if ({busy_o, pend_o, ovf_o} !== {1'b0, PW'(0), 1'b1} ||
        {led_o, busy_o, pend_o, ovf_o} !== model_outs()) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want %b", {led_o, busy_o, pend_o, ovf_o}, model_outs());
    end
    do_reset();
    n_tests++;
    if (ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b want 0", ovf_o);
    end
  endtask

  task automatic test_simultaneous();
    bit hit;
    hit = 1'b0;
    do_reset();
    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 20 && !hit; i++) begin
      if (gap_rem == 1) begin
        tick(1'b1);
        hit = 1'b1;
      end else begin
        tick(1'b0);
      end
    end
    n_tests++;
    if (!hit || {led_o, busy_o, pend_o} !== {1'b1, 1'b1, PW'(1)}) begin
      n_fail++;
      $display("FAIL simul: got %b want 1101 (reached=%b)", {led_o, busy_o, pend_o}, hit);
    end
  endtask

  task automatic test_reset_mid_on();
    do_reset();
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({led_o, busy_o, pend_o, ovf_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_on_reset: got %b want 0", {led_o, busy_o, pend_o, ovf_o});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (led_o !== (i < ON) || {led_o, busy_o, pend_o, ovf_o} !== model_outs()) begin
        n_fail++;
        $display("FAIL post_reset i%0d: got %b want %b", i,
                 {led_o, busy_o, pend_o, ovf_o}, model_outs());
      end
      tick(1'b0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit e;
      if (i < 300) e = ($urandom_range(0, 5) == 0);
      else         e = ($urandom_range(0, 1) == 0);
      tick(e);
      n_tests++;
      if ({led_o, busy_o, pend_o, ovf_o} !== model_outs()) begin
        n_fail++;
        $display("FAIL random i%0d: got %b want %b", i,
                 {led_o, busy_o, pend_o, ovf_o}, model_outs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef LED_STRETCH_QUEUE_EN
    test_queue();
    test_overflow();
    test_simultaneous();
`else
    test_retrigger();
`endif
    test_reset_mid_on();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
